// File: rtl/imem_loader.sv
// imem_loader: packs an incoming byte stream little-endian into 32-bit words
// and writes them to consecutive IMem addresses starting at 0.
module imem_loader #(
    parameter int word_size = 32,
    parameter int addr_bits = 8,
    parameter int depth     = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_data_i,
    input  logic                 byte_last_i,
    output logic                 byte_ready_o,
    output logic                 wr_en_o,
    output logic [addr_bits-1:0] wr_addr_o,
    output logic [word_size-1:0] wr_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [addr_bits:0]   word_count_o
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

    localparam logic [addr_bits-1:0] LastAddr = addr_bits'(depth - 1);

    state_e               state_q, state_d;
    logic [addr_bits-1:0] addr_q, addr_d;
    logic [1:0]           idx_q, idx_d;
    logic [word_size-1:0] word_q, word_d;
    logic                 last_q, last_d;
    logic                 error_q, error_d;
    logic [addr_bits:0]   count_q, count_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            last_q  <= last_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        last_d  = last_q;
        error_d = error_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    idx_d   = '0;
                    word_d  = '0;
                    last_d  = 1'b0;
                    error_d = 1'b0;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (byte_valid_i) begin
                    word_d[8*idx_q +: 8] = byte_data_i;
                    idx_d  = idx_q + 2'd1;
                    last_d = byte_last_i;
                    if (idx_q == 2'd3 || byte_last_i) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + 1'b1;
                if (last_q) begin
                    state_d = DONE;
                    error_d = 1'b0;
                end else if (addr_q == LastAddr) begin
                    // Image does not fit: stop rather than wrap over word 0.
                    state_d = DONE;
                    error_d = 1'b1;
                end else begin
                    state_d = LOAD;
                    addr_d  = addr_q + 1'b1;
                    idx_d   = '0;
                    word_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from state flops, so none are combinational in inputs.
    assign byte_ready_o = (state_q == LOAD);
    assign wr_en_o      = (state_q == WRITE);
    assign busy_o       = (state_q == LOAD) || (state_q == WRITE);
    assign done_o       = (state_q == DONE);
    assign error_o      = error_q;
    assign wr_addr_o    = addr_q;
    assign wr_data_o    = word_q;
    assign word_count_o = count_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to `IMem`. It accepts a byte stream over a valid/ready handshake and packs it little-endian into `word_size`-bit instructions. It writes them to consecutive word addresses of the IMem write port starting at 0, then reports completion so the CPU can be released from reset and fetch by PC. It sits between the boot/UART byte source and the IMem write port.

## Interface
- `word_size`, 32, instruction width; fixed at 4 bytes.
- `addr_bits`, 8, width of the IMem word address.
- `depth`, 256, number of IMem words; must equal 2**`addr_bits`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin a load; sampled only in IDLE or DONE.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_last`  in  1  qualifies `byte_data` as the final byte of the image.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  one-cycle IMem write strobe.
- `wr_addr`  out  `addr_bits`  IMem word address.
- `wr_data`  out  `word_size`  packed instruction.
- `busy`  out  1  load in progress (LOAD or WRITE).
- `done`  out  1  load finished; held until next `start` or reset.
- `error`  out  1  image exceeded `depth` words; valid while `done`=1.
- `word_count`  out  `addr_bits`+1  words written in current or last load.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- Reset (`rst_n`=0 at an edge) forces IDLE from any state and discards any partial word. It clears `byte_ready`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `error` and `word_count` to 0.
- IDLE/DONE with `start`=1:
  - go to LOAD;
  - clear address, byte index, assembly register, `word_count`, `done` and `error`.
- IDLE/DONE with `start`=0: hold state.
- `start` is ignored in LOAD and WRITE.
- LOAD:
  - `byte_ready`=1.
  - A byte is accepted when `byte_valid` and `byte_ready` are both high at an edge.
  - Byte index k (0..3) lands in bits [8k+7:8k].
  - On the 4th byte, or any byte with `byte_last`=1, go to WRITE.
  - Unfilled upper bytes of the word are zero.
- WRITE:
  - `byte_ready`=0; `wr_en`=1 for exactly one cycle; `wr_addr` is the current address; `wr_data` is the assembled word.
  - At the end of the cycle, `word_count` increments.
  - If the word carried `byte_last`, go to DONE with `error`=0.
  - Otherwise, if the address is `depth`-1, go to DONE with `error`=1. The address does not wrap and no further bytes are accepted.
  - Otherwise, increment the address, clear the byte index and assembly register, and return to LOAD.
- DONE: `done`=1, `busy`=0, `byte_ready`=0. `wr_addr`/`wr_data` hold their last values.
- `byte_last` on a non-handshake cycle is ignored.
- `byte_data` is ignored unless accepted.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Edge with `start` in IDLE → `busy`=1 and `byte_ready`=1 from the next cycle.
- Edge accepting the word's final byte → `wr_en`=1 in the next cycle. `byte_ready` is 0 in that same cycle.
- Minimum 5 cycles per full word: 4 accept cycles plus 1 write cycle.
- `done` rises in the cycle after the final WRITE cycle.
- `word_count` reflects the write one cycle after `wr_en`.
- Gaps in `byte_valid` stall LOAD indefinitely with no timeout.
- Reset asserted on the same edge as a byte handshake or write: reset wins. No write is issued and no count is updated.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with random inputs → every output is 0; after release, `byte_ready` stays 0 until `start`.
- Two words: send 13 00 00 00 93 80 10 00, with `byte_last` on the 8th byte → `wr_en` pulses at addr 0 with 0x00000013, then addr 1 with 0x00108093. Afterwards `done`=1, `error`=0, `word_count`=2.
- Partial word: send AA BB CC DD EE FF, with `byte_last` on FF → writes 0xDDCCBBAA at addr 0 and 0x0000FFEE at addr 1. Afterwards `done`=1 and `word_count`=2.
- Backpressure gaps: one idle `byte_valid` cycle between every byte of a single word → exactly one `wr_en`, with correct data; `byte_ready` is never high during the WRITE cycle.
- Overflow (`addr_bits`=2, `depth`=4): stream 17 bytes with no `byte_last` → 4 writes at addr 0..3. Afterwards `done`=1, `error`=1, `word_count`=4, and the 17th byte is never accepted (`byte_ready`=0).
- Reset mid-load: after 2 bytes of word 1, pulse `rst_n`=0 → no `wr_en` occurs. A new `start` plus 4 bytes then writes addr 0 with `word_count`=1.
